// File: rtl/vpu_seq_control_if.sv
// Fetch/issue bus: instruction BRAM read port plus the valid/ready
// issue channel to the VPU datapath.
interface vpu_seq_control_if #(
   parameter int INSTR_WIDTH = 32,
   parameter int PC_W        = 8
);
   logic [PC_W-1:0]        rd_addr;
   logic [INSTR_WIDTH-1:0] rd_data;
   logic                   issue_valid;
   logic [INSTR_WIDTH-1:0] issue_instr;
   logic                   issue_ready;

   modport master (
      output rd_addr,
      input  rd_data,
      output issue_valid,
      output issue_instr,
      input  issue_ready
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      input  issue_valid,
      input  issue_instr,
      output issue_ready
   );
endinterface

// File: rtl/vpu_seq_control.sv
// VPU sequencer: fetch/decode/issue FSM with nested hardware loops.
// Optional breakpoint support under `define VPU_SEQ_BREAKPOINT_EN.
module vpu_seq_control #(
   parameter int INSTR_WIDTH = 32,
   parameter int INSTR_DEPTH = 256,
   parameter int LOOP_DEPTH  = 4,
   parameter int CNT_WIDTH   = 16,
   localparam int PC_W       = $clog2(INSTR_DEPTH),
   localparam int LVL_W      = $clog2(LOOP_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   fsm_rst,
   input  logic                   step,
   input  logic                   run,
   input  logic                   halt,
`ifdef VPU_SEQ_BREAKPOINT_EN
   input  logic                   bp_en,
   input  logic [PC_W-1:0]        bp_addr,
`endif
   vpu_seq_control_if.master      bus,
   output logic [PC_W-1:0]        pc_out,
   output logic [INSTR_WIDTH-1:0] curr_instr_out,
   output logic [2:0]             state_out,
   output logic [LVL_W-1:0]       loop_level,
   output logic                   err
);
   localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_EXEC   = 3'd3,
      S_ISSUE  = 3'd4,
      S_HALTED = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [PC_W-1:0]        r_pc;
   logic [PC_W-1:0]        w_pc_nxt;
   logic [PC_W-1:0]        w_pc_inc;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [INSTR_WIDTH-1:0] r_issue;
   logic                   r_step_d;
   logic                   r_step_mode;
   logic                   w_step_mode_nxt;
   logic                   r_err;
   logic [LVL_W-1:0]       r_sp;
   logic [PC_W-1:0]        r_stk_addr [LOOP_DEPTH];
   logic [CNT_WIDTH-1:0]   r_stk_cnt  [LOOP_DEPTH];
   logic [IDX_W-1:0]       w_top;
   logic [IDX_W-1:0]       w_push_idx;
   logic [3:0]             w_ctrl;
   logic [CNT_WIDTH-1:0]   w_n;
   logic [CNT_WIDTH-1:0]   w_cnt_init;
   logic                   w_step_rise;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_top_live;
   logic                   w_op_halt;
   logic                   w_op_lstart;
   logic                   w_op_lend;
   logic                   w_op_jump;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_dec;
   logic                   w_err_set;
   logic                   w_latch;
   logic                   w_load_issue;
   logic                   w_boundary;
`ifdef VPU_SEQ_BREAKPOINT_EN
   logic                   r_bp_skip;
   logic                   w_bp_hit;
`endif

   assign w_pc_inc    = (r_pc == PC_W'(INSTR_DEPTH - 1)) ?
                        '0 : r_pc + PC_W'(1);
   assign w_step_rise = step & ~r_step_d;
   assign w_ctrl      = r_instr[INSTR_WIDTH-1 -: 4];
   assign w_n         = r_instr[CNT_WIDTH-1:0];
   // A zero count still runs the body once.
   assign w_cnt_init  = (w_n == '0) ? '0 : w_n - CNT_WIDTH'(1);
   assign w_full      = (r_sp == LVL_W'(LOOP_DEPTH));
   assign w_empty     = (r_sp == '0);
   assign w_top       = IDX_W'(r_sp - LVL_W'(1));
   assign w_push_idx  = IDX_W'(r_sp);
   assign w_top_live  = (r_stk_cnt[w_top] != '0);

   assign w_op_halt   = (w_ctrl == 4'hF);
   assign w_op_lstart = (w_ctrl == 4'hE);
   assign w_op_lend   = (w_ctrl == 4'hD);
   assign w_op_jump   = (w_ctrl == 4'hC);

   always_ff @(posedge clk) begin
      if (fsm_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_step_mode_nxt = r_step_mode;
      w_push          = 1'b0;
      w_pop           = 1'b0;
      w_dec           = 1'b0;
      w_err_set       = 1'b0;
      w_latch         = 1'b0;
      w_load_issue    = 1'b0;
      w_boundary      = 1'b0;
`ifdef VPU_SEQ_BREAKPOINT_EN
      w_bp_hit        = 1'b0;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt     = S_FETCH;
               w_step_mode_nxt = 1'b0;
            end else if (w_step_rise) begin
               w_state_nxt     = S_FETCH;
               w_step_mode_nxt = 1'b1;
            end
         end
         S_FETCH: begin
            w_state_nxt = S_LATCH;
`ifdef VPU_SEQ_BREAKPOINT_EN
            if (!r_step_mode && bp_en &&
                (r_pc == bp_addr) && !r_bp_skip) begin
               w_bp_hit    = 1'b1;
               w_state_nxt = S_IDLE;
            end
`endif
         end
         S_LATCH: begin
            w_latch     = 1'b1;
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            unique case (1'b1)
               w_op_halt: begin
                  w_state_nxt = S_HALTED;
               end
               w_op_lstart: begin
                  if (w_full) begin
                     w_err_set   = 1'b1;
                     w_state_nxt = S_ERROR;
                  end else begin
                     w_push     = 1'b1;
                     w_pc_nxt   = w_pc_inc;
                     w_boundary = 1'b1;
                  end
               end
               w_op_lend: begin
                  if (w_empty) begin
                     w_err_set   = 1'b1;
                     w_state_nxt = S_ERROR;
                  end else if (w_top_live) begin
                     w_dec      = 1'b1;
                     w_pc_nxt   = r_stk_addr[w_top];
                     w_boundary = 1'b1;
                  end else begin
                     w_pop      = 1'b1;
                     w_pc_nxt   = w_pc_inc;
                     w_boundary = 1'b1;
                  end
               end
               w_op_jump: begin
                  w_pc_nxt   = r_instr[PC_W-1:0];
                  w_boundary = 1'b1;
               end
               default: begin
                  w_load_issue = 1'b1;
                  w_state_nxt  = S_ISSUE;
               end
            endcase
         end
         S_ISSUE: begin
            if (bus.issue_ready) begin
               w_pc_nxt   = w_pc_inc;
               w_boundary = 1'b1;
            end
         end
         default: begin
            w_state_nxt = r_state;
         end
      endcase
      if (w_boundary) begin
         if (halt || r_step_mode || !run) begin
            w_state_nxt     = S_IDLE;
            w_step_mode_nxt = 1'b0;
         end else begin
            w_state_nxt = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fsm_rst) begin
         r_pc        <= '0;
         r_instr     <= '0;
         r_issue     <= '0;
         r_step_d    <= 1'b0;
         r_step_mode <= 1'b0;
         r_err       <= 1'b0;
         r_sp        <= '0;
         for (int i = 0; i < LOOP_DEPTH; i++) begin
            r_stk_addr[i] <= '0;
            r_stk_cnt[i]  <= '0;
         end
`ifdef VPU_SEQ_BREAKPOINT_EN
         r_bp_skip   <= 1'b0;
`endif
      end else begin
         r_pc        <= w_pc_nxt;
         r_step_d    <= step;
         r_step_mode <= w_step_mode_nxt;
         if (w_latch) begin
            r_instr <= bus.rd_data;
         end
         if (w_load_issue) begin
            r_issue <= r_instr;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         if (w_push) begin
            r_stk_addr[w_push_idx] <= w_pc_inc;
            r_stk_cnt[w_push_idx]  <= w_cnt_init;
            r_sp                   <= r_sp + LVL_W'(1);
         end else if (w_pop) begin
            r_sp <= r_sp - LVL_W'(1);
         end else if (w_dec) begin
            r_stk_cnt[w_top] <= r_stk_cnt[w_top] - CNT_WIDTH'(1);
         end
`ifdef VPU_SEQ_BREAKPOINT_EN
         // Arm again only once execution has moved off the breakpoint.
         if (w_bp_hit) begin
            r_bp_skip <= 1'b1;
         end else if (r_pc != bp_addr) begin
            r_bp_skip <= 1'b0;
         end
`endif
      end
   end

   assign bus.rd_addr     = r_pc;
   assign bus.issue_valid = (r_state == S_ISSUE);
   assign bus.issue_instr = r_issue;
   assign pc_out          = r_pc;
   assign curr_instr_out  = r_instr;
   assign state_out       = r_state;
   assign loop_level      = r_sp;
   assign err             = r_err;
endmodule

// File: tb/tb_vpu_seq_control.sv
// Bench for vpu_seq_control: directed scenarios plus random programs
// checked against an instruction-level interpreter.
module tb_vpu_seq_control;
   localparam int IW    = 32;
   localparam int DEPTH = 256;
   localparam int PW    = 8;
   localparam int LD    = 4;

   logic          clk = 1'b0;
   logic          fsm_rst = 1'b1;
   logic          step = 1'b0;
   logic          run = 1'b0;
   logic          halt = 1'b0;
`ifdef VPU_SEQ_BREAKPOINT_EN
   logic          bp_en = 1'b0;
   logic [PW-1:0] bp_addr = '0;
`endif
   logic [PW-1:0] pc_out;
   logic [IW-1:0] curr_instr_out;
   logic [2:0]    state_out;
   logic [2:0]    loop_level;
   logic          err;

   vpu_seq_control_if #(.INSTR_WIDTH(IW), .PC_W(PW)) bus ();

   vpu_seq_control #(
      .INSTR_WIDTH(IW),
      .INSTR_DEPTH(DEPTH),
      .LOOP_DEPTH(LD),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .fsm_rst(fsm_rst),
      .step(step),
      .run(run),
      .halt(halt),
`ifdef VPU_SEQ_BREAKPOINT_EN
      .bp_en(bp_en),
      .bp_addr(bp_addr),
`endif
      .bus(bus),
      .pc_out(pc_out),
      .curr_instr_out(curr_instr_out),
      .state_out(state_out),
      .loop_level(loop_level),
      .err(err)
   );

   always #5 clk = ~clk;

   logic [IW-1:0] mem [DEPTH];
   always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

   int            vectors = 0;
   int            miscompares = 0;
   logic [IW-1:0] got_i [$];
   int            got_l [$];
   logic [IW-1:0] exp_i [$];
   int            exp_l [$];
   bit            rdy_rand = 1'b0;
   logic          rdy_man = 1'b1;
   bit            prev_stall = 1'b0;
   logic [IW-1:0] prev_instr = '0;
   int            m_pc, m_state, m_err, m_lvl, m_n;

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", tag, act, req);
      end
   endtask

   function automatic logic [IW-1:0] got_at(input int i);
      return (got_i.size() > i) ? got_i[i] : 'x;
   endfunction

   task automatic cycle();
      @(negedge clk);
      bus.issue_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_man;
      if (prev_stall) begin
         check("hold_valid", bus.issue_valid, 1);
         check("hold_instr", bus.issue_instr, prev_instr);
      end
      prev_stall = bus.issue_valid && !bus.issue_ready && !fsm_rst;
      prev_instr = bus.issue_instr;
      if (bus.issue_valid && bus.issue_ready) begin
         got_i.push_back(bus.issue_instr);
         got_l.push_back(int'(loop_level));
      end
   endtask

   task automatic do_reset();
      run = 1'b0;
      step = 1'b0;
      halt = 1'b0;
      fsm_rst = 1'b1;
      prev_stall = 1'b0;
      cycle();
      cycle();
      fsm_rst = 1'b0;
      got_i.delete();
      got_l.delete();
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget,
                             input string tag);
      int k = 0;
      while (state_out !== s && k < budget) begin
         cycle();
         k++;
      end
      check(tag, state_out, s);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (state_out !== 3'd5 && state_out !== 3'd6 && k < budget) begin
         cycle();
         k++;
      end
   endtask

   task automatic step_pulse();
      step = 1'b1;
      cycle();
      step = 1'b0;
      wait_state(3'd0, 40, "step_idle");
   endtask

   task automatic fill_halt();
      foreach (mem[a]) mem[a] = 32'hF000_0000;
   endtask

   // Instruction-level interpreter of the sequencer ISA (run mode).
   task automatic model_run(output bit ok);
      int pc = 0;
      int sa [$];
      int sc [$];
      logic [IW-1:0] ins;
      bit done = 1'b0;
      exp_i.delete();
      exp_l.delete();
      m_n = 0;
      m_err = 0;
      while (!done && m_n < 400) begin
         ins = mem[pc];
         m_n++;
         case (ins[31:28])
            4'hF: begin
               m_state = 5;
               done = 1'b1;
            end
            4'hE: begin
               if (sa.size() == LD) begin
                  m_state = 6;
                  m_err = 1;
                  done = 1'b1;
               end else begin
                  sa.push_back((pc + 1) % DEPTH);
                  sc.push_back(ins[15:0] == 0 ? 0 : int'(ins[15:0]) - 1);
                  pc = (pc + 1) % DEPTH;
               end
            end
            4'hD: begin
               if (sa.size() == 0) begin
                  m_state = 6;
                  m_err = 1;
                  done = 1'b1;
               end else if (sc[sc.size()-1] != 0) begin
                  sc[sc.size()-1] = sc[sc.size()-1] - 1;
                  pc = sa[sa.size()-1];
               end else begin
                  void'(sa.pop_back());
                  void'(sc.pop_back());
                  pc = (pc + 1) % DEPTH;
               end
            end
            4'hC: pc = int'(ins[7:0]);
            default: begin
               exp_i.push_back(ins);
               exp_l.push_back(sa.size());
               pc = (pc + 1) % DEPTH;
            end
         endcase
      end
      m_pc = pc;
      m_lvl = sa.size();
      ok = done;
   endtask

   task automatic run_prog(input string tag);
      do_reset();
      run = 1'b1;
      wait_done(6 * m_n + 100);
      run = 1'b0;
      check({tag, "_nissue"}, got_i.size(), exp_i.size());
      foreach (exp_i[i]) begin
         if (i < got_i.size()) begin
            check({tag, "_instr"}, got_i[i], exp_i[i]);
            check({tag, "_level"}, got_l[i], exp_l[i]);
         end
      end
      check({tag, "_pc"}, pc_out, m_pc);
      check({tag, "_state"}, state_out, m_state);
      check({tag, "_err"}, err, m_err);
      check({tag, "_lvl"}, loop_level, m_lvl);
   endtask

   task automatic gen_prog();
      int len = $urandom_range(10, 20);
      int r;
      fill_halt();
      for (int a = 0; a < len - 1; a++) begin
         r = $urandom_range(0, 99);
         if (r < 50)
            mem[a] = {4'($urandom_range(0, 11)), 28'($urandom)};
         else if (r < 68)
            mem[a] = {4'hE, 12'($urandom), 16'($urandom_range(0, 3))};
         else if (r < 88)
            mem[a] = {4'hD, 28'($urandom)};
         else
            mem[a] = {4'hC, 20'($urandom), 8'($urandom_range(a + 1, len - 1))};
      end
   endtask

   initial begin
      bit ok;
      int tries;
      bus.issue_ready = 1'b1;
      fill_halt();
      do_reset();
      check("rst_state", state_out, 0);
      check("rst_valid", bus.issue_valid, 0);
      check("rst_pc", pc_out, 0);
      check("rst_err", err, 0);

      // Single stepping
      mem[0] = 32'h0000_0001;
      mem[1] = 32'h0000_0002;
      mem[2] = 32'h0000_0003;
      do_reset();
      step_pulse();
      check("step1_n", got_i.size(), 1);
      check("step1_instr", bus.issue_instr, 32'h1);
      check("step1_pc", pc_out, 1);
      step_pulse();
      check("step2_instr", got_at(1), 32'h2);
      check("step2_pc", pc_out, 2);
      step_pulse();
      check("step3_instr", got_at(2), 32'h3);
      check("step3_pc", pc_out, 3);
      repeat (4) cycle();
      check("step_stay_idle", state_out, 0);

      // Counted loop in run mode
      fill_halt();
      mem[0] = 32'hE000_0003;
      mem[1] = 32'h0000_00AA;
      mem[2] = 32'hD000_0000;
      model_run(ok);
      run_prog("loop");
      check("loop_n3", got_i.size(), 3);
      check("loop_body_lvl", (got_l.size() > 1) ? got_l[1] : -1, 1);
      check("loop_halted", state_out, 5);
      check("loop_pc3", pc_out, 3);

      // Backpressure with halt pending
      fill_halt();
      mem[0] = 32'h0000_0077;
      do_reset();
      rdy_man = 1'b0;
      halt = 1'b1;
      run = 1'b1;
      wait_state(3'd4, 20, "bp_reach_issue");
      run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("bp_valid", bus.issue_valid, 1);
         check("bp_instr", bus.issue_instr, 32'h77);
      end
      rdy_man = 1'b1;
      cycle();
      cycle();
      check("bp_idle", state_out, 0);
      check("bp_valid_drop", bus.issue_valid, 0);
      check("bp_pc", pc_out, 1);
      check("bp_issued", got_at(0), 32'h77);
      repeat (3) cycle();
      check("bp_stay_idle", state_out, 0);
      halt = 1'b0;
      do_reset();
      check("rst2_pc", pc_out, 0);
      check("rst2_rdaddr", bus.rd_addr, 0);
      check("rst2_instr", curr_instr_out, 0);
      check("rst2_issue", bus.issue_instr, 0);
      check("rst2_state", state_out, 0);

      // Reset in the middle of a handshake
      run = 1'b1;
      rdy_man = 1'b0;
      wait_state(3'd4, 20, "mid_reach_issue");
      fsm_rst = 1'b1;
      prev_stall = 1'b0;
      cycle();
      check("mid_rst_valid", bus.issue_valid, 0);
      check("mid_rst_state", state_out, 0);
      fsm_rst = 1'b0;
      run = 1'b0;
      rdy_man = 1'b1;

      // Loop stack errors
      fill_halt();
      mem[0] = 32'hD000_0000;
      model_run(ok);
      run_prog("err_empty");
      check("err_empty_flag", err, 1);
      check("err_empty_state", state_out, 6);
      fill_halt();
      for (int a = 0; a <= LD; a++) mem[a] = 32'hE000_0002;
      model_run(ok);
      run_prog("err_ovf");
      check("err_ovf_flag", err, 1);
      do_reset();
      check("err_clr", err, 0);
      check("err_clr_state", state_out, 0);
      check("err_clr_lvl", loop_level, 0);

      // Jump to the last word and wrap
      fill_halt();
      mem[0] = 32'hC000_00FF;
      mem[255] = 32'h0000_0055;
      do_reset();
      step_pulse();
      check("jmp_pc", pc_out, 255);
      check("jmp_noissue", got_i.size(), 0);
      step_pulse();
      check("wrap_instr", got_at(0), 32'h55);
      check("wrap_pc", pc_out, 0);
      check("wrap_err", err, 0);

`ifdef VPU_SEQ_BREAKPOINT_EN
      fill_halt();
      mem[0] = 32'h0000_0011;
      mem[1] = 32'h0000_0022;
      mem[2] = 32'h0000_0033;
      do_reset();
      bp_en = 1'b1;
      bp_addr = 8'd2;
      run = 1'b1;
      cycle();
      for (int k = 0; k < 100 && state_out !== 3'd0; k++) cycle();
      run = 1'b0;
      check("brk_state", state_out, 0);
      check("brk_pc", pc_out, 2);
      check("brk_nissue", got_i.size(), 2);
      run = 1'b1;
      wait_done(100);
      run = 1'b0;
      check("brk_resume", got_at(2), 32'h33);
      check("brk_final_pc", pc_out, 3);
      check("brk_final_state", state_out, 5);
      bp_en = 1'b0;
`endif

      // Random programs with random backpressure
      rdy_rand = 1'b1;
      for (int p = 0; p < 30; p++) begin
         tries = 0;
         do begin
            gen_prog();
            model_run(ok);
            tries++;
         end while (!ok && tries < 20);
         if (ok) run_prog("rnd");
      end
      rdy_rand = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vpu_seq_control.md
Name: vpu_seq_control

Overview:
Parametrised successor to the tiny FSM controller. It fetches instructions from synchronous instruction memory and supports step, run and halt. It adds hardware loops (nested, counted), jumps, a HALT opcode, and a valid/ready issue handshake to the VPU datapath. It sits between the instruction BRAM and the systolic/vector datapath, and exposes PC, instruction and state for debug.

Parameters:
INSTR_WIDTH, 32, instruction word width (must be >= 24)
INSTR_DEPTH, 256, instruction memory depth; PC_W = $clog2(INSTR_DEPTH)
LOOP_DEPTH, 4, nesting depth of the hardware loop stack
CNT_WIDTH, 16, loop count width (taken from instr[CNT_WIDTH-1:0])

Ports:
clk  in  1  clock
fsm_rst  in  1  synchronous, active-high reset
step  in  1  single-step request (rising-edge detected internally)
run  in  1  level: continuous execution while high
halt  in  1  stop at next instruction boundary
rd_addr  out  PC_W  instruction memory address
rd_data  in  INSTR_WIDTH  instruction memory data, valid 1 cycle after rd_addr
issue_valid  out  1  datapath instruction valid
issue_instr  out  INSTR_WIDTH  datapath instruction
issue_ready  in  1  datapath accepts
pc_out  out  PC_W  current PC
curr_instr_out  out  INSTR_WIDTH  last latched instruction
state_out  out  3  FSM state encoding
loop_level  out  $clog2(LOOP_DEPTH+1)  active loop nesting
err  out  1  sticky error flag

Behaviour:
- Reset (fsm_rst high on a clk edge): all outputs are 0. State is IDLE. Loop stack is cleared. step edge detector is cleared. Reset mid-handshake drops issue_valid on the next cycle.
- States and encodings: IDLE=0, FETCH=1, LATCH=2, EXEC=3, ISSUE=4, HALTED=5, ERROR=6.
- IDLE: a step rising edge sets a one-shot flag and moves to FETCH. run=1 also moves to FETCH. If both are present, run wins.
- FETCH: rd_addr = pc. Next cycle goes to LATCH.
- LATCH: curr_instr_out <= rd_data. Next cycle goes to EXEC.
- EXEC decodes ctrl = instr[INSTR_WIDTH-1 -: 4]:
  - 4'hF HALT: go to HALTED. pc is unchanged.
  - 4'hE LOOP_START: count N = instr[CNT_WIDTH-1:0]. Push {pc+1, N-1}. N=0 is treated as 1 (body runs once, no error). A push when the stack holds LOOP_DEPTH entries sets err and goes to ERROR.
  - 4'hD LOOP_END: if the top count is nonzero, decrement it and set pc = top start address. Otherwise pop and set pc = pc+1. With an empty stack, set err and go to ERROR.
  - 4'hC JUMP: pc = instr[PC_W-1:0].
  - Any other ctrl: go to ISSUE with issue_instr = instr.
  - Control opcodes complete in EXEC. Each adds 3 cycles per instruction (FETCH, LATCH, EXEC).
- ISSUE: issue_valid=1, with issue_instr held stable until issue_ready. On the valid&&ready cycle, pc = pc+1 and issue_valid drops the next cycle. halt or run deassertion never drops valid early.
- Instruction boundary (end of EXEC control op or ISSUE accept):
  - If halt=1, or step mode is active, or run=0: go to IDLE.
  - Otherwise go to FETCH.
- PC wraps from INSTR_DEPTH-1 to 0 on increment; no error.
- HALTED: holds until fsm_rst. In HALTED, step and run are ignored.
- ERROR: err is sticky. Holds until fsm_rst.
- loop_level = number of stack entries.

Optional Feature:
Macro: VPU_SEQ_BREAKPOINT_EN.
- Defined: adds ports bp_en (in, 1) and bp_addr (in, PC_W). In run mode, at entry to FETCH with bp_en=1 and pc==bp_addr, the block goes to IDLE without fetching. The next step or run executes the instruction at bp_addr; the breakpoint is not re-triggered until pc leaves bp_addr.
- Undefined: these ports do not exist and behaviour is as above.

Test Plan:
- Step: mem[0]=32'h0000_0001, mem[1]=32'h0000_0002, issue_ready=1, three step pulses -> issue_instr 00000001 then 00000002, pc 1 then 2, state_out returns to 0 after each.
- Run with loop: mem = {E000_0003, 0000_00AA, D000_0000, F000_0000}, run=1 -> exactly 3 AA issues, loop_level 1 during body then 0, final state_out=5, pc=3.
- Backpressure: issue_ready low 5 cycles during ISSUE with halt asserted -> issue_valid and issue_instr held stable for 5 cycles, then accept, then state IDLE.
- Errors: LOOP_END with empty stack -> err=1, state_out=6. LOOP_DEPTH+1 nested LOOP_STARTs -> err=1. fsm_rst clears both.
- Jump/wrap: mem[255]=0000_0055, mem[0]=C000_00FF at pc 0 -> jumps to 255, issues 55, pc wraps to 0.
- Breakpoint (VPU_SEQ_BREAKPOINT_EN): bp_addr=2, run=1 -> stops in IDLE with pc=2 and mem[2] not issued. Re-run -> mem[2] issued.
